// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rf_access_ctrl
// Brief   : Register-file front end: reset clear sweep, then core/debug sharing
// Revision: 1.0
// ============================================================================
module rf_access_ctrl #(
    parameter logic [31:0] INIT_VALUE     = 32'h00000000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_we,
    input  logic [4:0]  core_wa,
    input  logic [31:0] core_wd,
    input  logic [4:0]  core_ra2,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd2
);

    localparam logic [2:0] c_ST_INIT   = 3'd0;
    localparam logic [2:0] c_ST_IDLE   = 3'd1;
    localparam logic [2:0] c_ST_DBG    = 3'd2;
    localparam logic [2:0] c_ST_ACK    = 3'd3;
    localparam logic [2:0] c_ST_WAITLO = 3'd4;

    localparam logic [2:0] c_ST_RESET  = CLEAR_ON_RESET ? c_ST_INIT : c_ST_IDLE;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [4:0]  r_idx;
    logic [31:0] r_dbg_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT:   if (r_idx == 5'd31) w_state_nxt = c_ST_IDLE;
            c_ST_IDLE:   if (dbg_req) w_state_nxt = c_ST_DBG;
            c_ST_DBG:    w_state_nxt = c_ST_ACK;
            c_ST_ACK:    w_state_nxt = dbg_req ? c_ST_WAITLO : c_ST_IDLE;
            c_ST_WAITLO: if (!dbg_req) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RESET;
            r_idx       <= 5'd1;
            r_dbg_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            // Index parks back at 1 so a later sweep always starts clean
            if (r_state == c_ST_INIT) begin
                r_idx <= (r_idx == 5'd31) ? 5'd1 : r_idx + 5'd1;
            end
            if (r_state == c_ST_DBG && !dbg_wr) begin
                r_dbg_rdata <= (dbg_addr == 5'd0) ? 32'd0 : rf_rd2;
            end
        end
    end

    always_comb begin
        rf_we      = core_we;
        rf_wa      = core_wa;
        rf_wd      = core_wd;
        rf_ra2     = core_ra2;
        core_stall = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                rf_we      = 1'b1;
                rf_wa      = r_idx;
                rf_wd      = INIT_VALUE;
                core_stall = 1'b1;
            end
            c_ST_DBG: begin
                // Core writeback is gated off; only the debug write may land
                rf_we      = dbg_wr && (dbg_addr != 5'd0);
                rf_wa      = dbg_addr;
                rf_wd      = dbg_wdata;
                rf_ra2     = dbg_addr;
                core_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_ack   = (r_state == c_ST_ACK);
    assign dbg_rdata = r_dbg_rdata;

endmodule
`default_nettype wire
